uart_tx_sched: RTL

//  Sequencer between the TX sync FIFO and the UART bit serialiser. Pops bytes

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_sched.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and default widths for the TX scheduler, sync FIFO
// and bit serialiser.
package uart_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int GAP_W_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        FETCH,
        START,
        BUSY,
        GAP
    } tx_sched_state_t;

endpackage

// File: rtl/uart_tx_sched.sv
// TX frame scheduler: FIFO pop -> serialiser start, inter-frame gap, flush.
// Optional CTS gating is enabled by defining UART_TX_CTS_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int GAP_W  = GAP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rstn,
`ifdef UART_TX_CTS_EN
    input  logic              cts_n,
`endif
    input  logic              tx_enable,
    input  logic              tx_flush,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_out,
    output logic              fifo_pop,
    output logic              fifo_reset,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DWIDTH-1:0] tx_data,
    output logic              sched_idle,
    output logic [CNT_W-1:0]  frames_sent
);

    tx_sched_state_t  state;
    logic [GAP_W-1:0] gap_cnt;
    logic             cts_ok;
    logic             can_start;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync;

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            cts_sync <= 2'b11;
        end else begin
            cts_sync <= {cts_sync[0], cts_n};
        end
    end

    assign cts_ok = ~cts_sync[1];
`else
    assign cts_ok = 1'b1;
`endif

    // Hold off while a FIFO reset is pending so we never pop a dying entry.
    assign can_start = tx_enable & ~fifo_empty & ~tx_busy
                     & ~tx_flush & ~fifo_reset & cts_ok;

    assign sched_idle = (state == IDLE) & ~tx_busy;

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            fifo_pop    <= 1'b0;
            fifo_reset  <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            frames_sent <= '0;
        end else begin
            fifo_pop   <= 1'b0;
            tx_start   <= 1'b0;
            fifo_reset <= tx_flush;
            unique case (state)
                IDLE: begin
                    if (can_start) begin
                        state    <= POP;
                        fifo_pop <= 1'b1;
                    end
                end
                POP: begin
                    state <= tx_flush ? IDLE : FETCH;
                end
                FETCH: begin
                    if (tx_flush) begin
                        state <= IDLE;
                    end else begin
                        tx_data     <= fifo_out;
                        tx_start    <= 1'b1;
                        frames_sent <= frames_sent + 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (!tx_busy) begin
                        if (gap_cycles == '0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cycles;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= 1) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
